// File: rtl/vr_wheel_gen.sv
// Synthetic N-minus-M crank trigger-wheel generator driving a single VR-style line.
// Define VR_WHEEL_GEN_REV_CNT_EN to add the 16-bit rev_cnt revolution counter output.
module vr_wheel_gen #(
    parameter int W  = 16,
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          load,
    input  logic [TW-1:0] teeth_total,
    input  logic [TW-1:0] teeth_missing,
    input  logic [W-1:0]  period,
    input  logic [W-1:0]  high_time,
    output logic          vr_out,
    output logic [TW-1:0] tooth_num,
    output logic          gap,
    output logic          rev_pulse,
    output logic          busy,
    output logic          cfg_err
`ifdef VR_WHEEL_GEN_REV_CNT_EN
   ,output logic [15:0]   rev_cnt
`endif
);

    // state | meaning
    // IDLE  | stopped; active config follows shadow every cycle
    // HIGH  | high part of a real tooth
    // LOW   | low part of a real tooth
    // GAP   | missing-tooth positions
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [TW-1:0] tt_sh_q, tm_sh_q, tt_q, tm_q;
    logic [W-1:0]  per_sh_q, ht_sh_q, per_q, ht_q;
    logic [W-1:0]  per_san, ht_san;
    logic [W-1:0]  phase_q, phase_d;
    logic [TW-1:0] tooth_q, tooth_d, real_last;
    logic [1:0]    state_q, state_d;
    logic          ena_q, sh_valid, copy_d, wrap_d, rev_d;

    always_comb begin
        per_san = (per_sh_q < W'(2)) ? W'(2) : per_sh_q;
        if (ht_sh_q == '0)
            ht_san = W'(1);
        else if (ht_sh_q >= per_san)
            ht_san = per_san - W'(1);
        else
            ht_san = ht_sh_q;
        sh_valid  = (tt_sh_q != '0) && (tm_sh_q < tt_sh_q);
        real_last = tt_q - tm_q - TW'(1);
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        tooth_d = tooth_q;
        copy_d  = 1'b0;
        wrap_d  = 1'b0;
        rev_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                copy_d  = 1'b1;
                phase_d = '0;
                tooth_d = '0;
                if (sh_valid) begin
                    state_d = S_HIGH;
                    rev_d   = 1'b1;
                end
            end
            S_HIGH: begin
                phase_d = phase_q + W'(1);
                if (phase_q == ht_q - W'(1))
                    state_d = S_LOW;
            end
            S_LOW: begin
                if (phase_q == per_q - W'(1)) begin
                    phase_d = '0;
                    if (tooth_q != real_last) begin
                        state_d = S_HIGH;
                        tooth_d = tooth_q + TW'(1);
                    end else if (tm_q != '0) begin
                        state_d = S_GAP;
                        tooth_d = tooth_q + TW'(1);
                    end else begin
                        wrap_d = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + W'(1);
                end
            end
            S_GAP: begin
                if (phase_q == per_q - W'(1)) begin
                    phase_d = '0;
                    if (tooth_q == tt_q - TW'(1))
                        wrap_d = 1'b1;
                    else
                        tooth_d = tooth_q + TW'(1);
                end else begin
                    phase_d = phase_q + W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Revolution boundary: take the shadow config, stop cleanly if it is invalid.
        if (wrap_d) begin
            copy_d  = 1'b1;
            rev_d   = sh_valid;
            state_d = sh_valid ? S_HIGH : S_IDLE;
            phase_d = '0;
            tooth_d = '0;
        end

        if (!ena_q) begin
            state_d = S_IDLE;
            phase_d = '0;
            tooth_d = '0;
            rev_d   = 1'b0;
            wrap_d  = 1'b0;
            copy_d  = (state_q == S_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt_sh_q  <= '0;
            tm_sh_q  <= '0;
            per_sh_q <= '0;
            ht_sh_q  <= '0;
        end else if (load) begin
            tt_sh_q  <= teeth_total;
            tm_sh_q  <= teeth_missing;
            per_sh_q <= period;
            ht_sh_q  <= high_time;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt_q    <= '0;
            tm_q    <= '0;
            per_q   <= '0;
            ht_q    <= '0;
            cfg_err <= 1'b1;
        end else if (copy_d) begin
            tt_q    <= tt_sh_q;
            tm_q    <= tm_sh_q;
            per_q   <= per_san;
            ht_q    <= ht_san;
            cfg_err <= !sh_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ena_q     <= 1'b0;
            state_q   <= S_IDLE;
            phase_q   <= '0;
            tooth_q   <= '0;
            vr_out    <= 1'b0;
            gap       <= 1'b0;
            busy      <= 1'b0;
            rev_pulse <= 1'b0;
        end else begin
            ena_q     <= ena;
            state_q   <= state_d;
            phase_q   <= phase_d;
            tooth_q   <= tooth_d;
            vr_out    <= (state_d == S_HIGH);
            gap       <= (state_d == S_GAP);
            busy      <= (state_d != S_IDLE);
            rev_pulse <= rev_d;
        end
    end

    assign tooth_num = tooth_q;

`ifdef VR_WHEEL_GEN_REV_CNT_EN
    // Only wrap pulses count; the start-up pulse out of IDLE does not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rev_cnt <= '0;
        else if (wrap_d && rev_d)
            rev_cnt <= rev_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vr_wheel_gen.sv
// Self-checking bench for vr_wheel_gen: revolution-time reference model plus scenario tasks.
// Build with VR_WHEEL_GEN_REV_CNT_EN defined to also exercise rev_cnt.
module tb_vr_wheel_gen;
    localparam int W  = 16;
    localparam int TW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b0;
    logic          load = 1'b0;
    logic [TW-1:0] teeth_total = '0;
    logic [TW-1:0] teeth_missing = '0;
    logic [W-1:0]  period = '0;
    logic [W-1:0]  high_time = '0;
    logic          vr_out, gap, rev_pulse, busy, cfg_err;
    logic [TW-1:0] tooth_num;
`ifdef VR_WHEEL_GEN_REV_CNT_EN
    logic [15:0]   rev_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vr_wheel_gen #(.W(W), .TW(TW)) dut (
        .clk(clk), .rst(rst), .ena(ena), .load(load),
        .teeth_total(teeth_total), .teeth_missing(teeth_missing),
        .period(period), .high_time(high_time),
        .vr_out(vr_out), .tooth_num(tooth_num), .gap(gap),
        .rev_pulse(rev_pulse), .busy(busy), .cfg_err(cfg_err)
`ifdef VR_WHEEL_GEN_REV_CNT_EN
       ,.rev_cnt(rev_cnt)
`endif
    );

    logic [TW+4:0] dut_vec;
    assign dut_vec = {vr_out, gap, rev_pulse, busy, cfg_err, tooth_num};

    // Reference model: position within the revolution as a plain cycle count m_t.
    int s_tt = 0, s_tm = 0, s_per = 0, s_ht = 0;
    int a_tt = 0, a_tm = 0, a_per = 0, a_ht = 0;
    int m_t = 0, m_revcnt = 0;
    bit m_err = 1'b1, m_run = 1'b0, m_rev = 1'b0, m_ena_q = 1'b0;
    bit m_shv, m_was;

    function automatic int san_per(int p);
        return (p < 2) ? 2 : p;
    endfunction

    function automatic int san_ht(int h, int p);
        if (h == 0) return 1;
        if (h >= p) return p - 1;
        return h;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_tt = 0; s_tm = 0; s_per = 0; s_ht = 0;
            a_tt = 0; a_tm = 0; a_per = 0; a_ht = 0;
            m_t = 0; m_revcnt = 0; m_err = 1'b1; m_run = 1'b0; m_rev = 1'b0; m_ena_q = 1'b0;
        end else begin
            m_shv = (s_tt != 0) && (s_tm < s_tt);
            m_was = m_run;
            if (!m_was) begin
                a_tt = s_tt; a_tm = s_tm; a_per = san_per(s_per); a_ht = san_ht(s_ht, a_per);
                m_err = !m_shv;
            end
            if (!m_ena_q) begin
                m_run = 1'b0; m_t = 0; m_rev = 1'b0;
            end else if (!m_was) begin
                m_run = m_shv; m_t = 0; m_rev = m_shv;
            end else if (m_t + 1 == a_tt * a_per) begin
                a_tt = s_tt; a_tm = s_tm; a_per = san_per(s_per); a_ht = san_ht(s_ht, a_per);
                m_err = !m_shv;
                m_t = 0; m_run = m_shv; m_rev = m_shv;
                if (m_shv) m_revcnt = (m_revcnt + 1) % 65536;
            end else begin
                m_t = m_t + 1; m_rev = 1'b0;
            end
            if (load) begin
                s_tt = int'(teeth_total); s_tm = int'(teeth_missing);
                s_per = int'(period); s_ht = int'(high_time);
            end
            m_ena_q = ena;
        end
    end

    function automatic logic [TW+4:0] exp_vec();
        int tooth, ph;
        logic v, g;
        tooth = 0; ph = 0;
        if (m_run) begin
            tooth = m_t / a_per;
            ph = m_t % a_per;
        end
        v = m_run && (tooth < a_tt - a_tm) && (ph < a_ht);
        g = m_run && (tooth >= a_tt - a_tm);
        return {v, g, m_rev, m_run, m_err, TW'(tooth)};
    endfunction

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if (dut_vec !== {5'b00001, TW'(0)}) begin
            n_fail++; $display("FAIL reset_held: got %h, expected %h", dut_vec, {5'b00001, TW'(0)});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (dut_vec !== {5'b00001, TW'(0)}) begin
            n_fail++; $display("FAIL reset_released: got %h, expected %h", dut_vec, {5'b00001, TW'(0)});
        end
    endtask

    task automatic test_wheel_60_2();
        int last_rev = 0, pulses = 0, rec_int = -1, rec_pulses = -1;
        int gap_run = 0, gap_max = 0, low_run = 0, low_max = 0, tooth_max = 0;
        bit seen = 0, prev_vr = 0;
        @(negedge clk);
        teeth_total = 8'd60; teeth_missing = 8'd2; period = 16'd10; high_time = 16'd5; load = 1'b1;
        @(negedge clk);
        load = 1'b0; ena = 1'b1;
        for (int cyc = 0; cyc < 1300; cyc++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL wheel_model cyc %0d: got %h, expected %h", cyc, dut_vec, exp_vec());
            end
            if (rev_pulse) begin
                if (seen) begin rec_int = cyc - last_rev; rec_pulses = pulses; end
                pulses = 0; last_rev = cyc; seen = 1;
            end
            if (vr_out && !prev_vr) pulses++;
            prev_vr = vr_out;
            gap_run = gap ? gap_run + 1 : 0;
            if (gap_run > gap_max) gap_max = gap_run;
            low_run = (busy && !vr_out) ? low_run + 1 : 0;
            if (low_run > low_max) low_max = low_run;
            if (busy && int'(tooth_num) > tooth_max) tooth_max = int'(tooth_num);
        end
        n_chk++;
        if (rec_int != 600) begin n_fail++; $display("FAIL wheel_rev_interval: got %0d, expected 600", rec_int); end
        n_chk++;
        if (rec_pulses != 58) begin n_fail++; $display("FAIL wheel_pulse_count: got %0d, expected 58", rec_pulses); end
        n_chk++;
        if (gap_max != 20) begin n_fail++; $display("FAIL wheel_gap_len: got %0d, expected 20", gap_max); end
        n_chk++;
        if (low_max != 25) begin n_fail++; $display("FAIL wheel_low_stretch: got %0d, expected 25", low_max); end
        n_chk++;
        if (tooth_max != 59) begin n_fail++; $display("FAIL wheel_tooth_max: got %0d, expected 59", tooth_max); end
    endtask

    task automatic test_sanitise();
        int hi_run = 0, hi_max = 0, last_rev = -1, rec_int = -1;
        ena = 1'b0;
        teeth_total = 8'd4; teeth_missing = 8'd1; period = 16'd10; high_time = 16'd12; load = 1'b1;
        @(negedge clk);
        load = 1'b0; ena = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL sanitise_ht_model cyc %0d: got %h, expected %h", cyc, dut_vec, exp_vec());
            end
            hi_run = vr_out ? hi_run + 1 : 0;
            if (hi_run > hi_max) hi_max = hi_run;
        end
        n_chk++;
        if (hi_max != 9) begin n_fail++; $display("FAIL sanitise_high_clamp: got %0d, expected 9", hi_max); end
        ena = 1'b0; period = 16'd1; high_time = 16'd5; load = 1'b1;
        @(negedge clk);
        load = 1'b0; ena = 1'b1;
        hi_max = 0; hi_run = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL sanitise_per_model cyc %0d: got %h, expected %h", cyc, dut_vec, exp_vec());
            end
            hi_run = vr_out ? hi_run + 1 : 0;
            if (hi_run > hi_max) hi_max = hi_run;
            if (rev_pulse) begin
                if (last_rev >= 0) rec_int = cyc - last_rev;
                last_rev = cyc;
            end
        end
        n_chk++;
        if (hi_max != 1) begin n_fail++; $display("FAIL sanitise_per_high: got %0d, expected 1", hi_max); end
        n_chk++;
        if (rec_int != 8) begin n_fail++; $display("FAIL sanitise_per_rev: got %0d, expected 8", rec_int); end
    endtask

    task automatic test_invalid();
        int edges = 0;
        ena = 1'b0;
        teeth_total = 8'd60; teeth_missing = 8'd60; period = 16'd10; high_time = 16'd5; load = 1'b1;
        @(negedge clk);
        load = 1'b0; ena = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL invalid_model cyc %0d: got %h, expected %h", cyc, dut_vec, exp_vec());
            end
        end
        n_chk++;
        if (cfg_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL invalid_hold: got cfg_err=%b busy=%b, expected cfg_err=1 busy=0", cfg_err, busy);
        end
        teeth_missing = 8'd2; load = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            load = 1'b0; edges++;
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL invalid_recover_model cyc %0d: got %h, expected %h", i, dut_vec, exp_vec());
            end
            if (busy) break;
        end
        n_chk++;
        if (!(busy === 1'b1 && cfg_err === 1'b0 && edges <= 2)) begin
            n_fail++; $display("FAIL invalid_recover_start: got busy=%b cfg_err=%b after %0d cycles, expected busy=1 cfg_err=0 within 2", busy, cfg_err, edges);
        end
    endtask

    task automatic test_retime();
        bit found = 0;
        int r1 = -1, r2 = -1;
        for (int cyc = 0; cyc < 1300; cyc++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL retime_seek_model cyc %0d: got %h, expected %h", cyc, dut_vec, exp_vec());
            end
            if (busy && tooth_num == 8'd30) begin found = 1; break; end
        end
        n_chk++;
        if (!found) begin n_fail++; $display("FAIL retime_find_tooth30: got not found, expected found"); end
        period = 16'd20; load = 1'b1;
        for (int cyc = 1; cyc <= 1600; cyc++) begin
            @(negedge clk);
            load = 1'b0;
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL retime_model cyc %0d: got %h, expected %h", cyc, dut_vec, exp_vec());
            end
            if (rev_pulse) begin
                if (r1 < 0) r1 = cyc;
                else if (r2 < 0) r2 = cyc;
            end
            if (r2 >= 0) break;
        end
        n_chk++;
        if (r1 != 300) begin n_fail++; $display("FAIL retime_old_remainder: got %0d, expected 300", r1); end
        n_chk++;
        if (r2 - r1 != 1200) begin n_fail++; $display("FAIL retime_new_rev_len: got %0d, expected 1200", r2 - r1); end
    endtask

    task automatic test_ena_drop();
        bit found = 0;
        int edges = 0;
        for (int cyc = 0; cyc < 1300; cyc++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL ena_seek_model cyc %0d: got %h, expected %h", cyc, dut_vec, exp_vec());
            end
            if (busy && vr_out && tooth_num == 8'd17) begin found = 1; break; end
        end
        n_chk++;
        if (!found) begin n_fail++; $display("FAIL ena_find_tooth17: got not found, expected found"); end
        ena = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL ena_drop_model: got %h, expected %h", dut_vec, exp_vec());
            end
        end
        n_chk++;
        if ({vr_out, gap, rev_pulse, busy, tooth_num} !== '0) begin
            n_fail++; $display("FAIL ena_drop_outputs: got %h, expected 0", {vr_out, gap, rev_pulse, busy, tooth_num});
        end
        ena = 1'b1;
        found = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            edges++;
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL ena_restart_model cyc %0d: got %h, expected %h", i, dut_vec, exp_vec());
            end
            if (rev_pulse) begin found = 1; break; end
        end
        n_chk++;
        if (!(found && tooth_num == 8'd0 && vr_out && edges == 2)) begin
            n_fail++; $display("FAIL ena_restart: got rev=%b tooth=%0d vr=%b after %0d cycles, expected rev=1 tooth=0 vr=1 after 2", found, tooth_num, vr_out, edges);
        end
    endtask

    task automatic test_async_rst();
        bit found = 0;
        for (int cyc = 0; cyc < 1300; cyc++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL rst_seek_model cyc %0d: got %h, expected %h", cyc, dut_vec, exp_vec());
            end
            if (gap) begin found = 1; break; end
        end
        n_chk++;
        if (!found) begin n_fail++; $display("FAIL rst_find_gap: got not found, expected found"); end
`ifdef VR_WHEEL_GEN_REV_CNT_EN
        n_chk++;
        if (rev_cnt !== 16'(m_revcnt)) begin
            n_fail++; $display("FAIL rst_revcnt_before: got %0d, expected %0d", rev_cnt, m_revcnt);
        end
`endif
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (dut_vec !== {5'b00001, TW'(0)}) begin
            n_fail++; $display("FAIL rst_async_immediate: got %h, expected %h", dut_vec, {5'b00001, TW'(0)});
        end
`ifdef VR_WHEEL_GEN_REV_CNT_EN
        n_chk++;
        if (rev_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_revcnt_clear: got %0d, expected 0", rev_cnt); end
`endif
        ena = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

`ifdef VR_WHEEL_GEN_REV_CNT_EN
    task automatic test_rev_cnt();
        int revs = 0;
        teeth_total = 8'd4; teeth_missing = 8'd1; period = 16'd3; high_time = 16'd1; load = 1'b1;
        @(negedge clk);
        load = 1'b0; ena = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            n_chk++;
            if (dut_vec !== exp_vec() || rev_cnt !== 16'(m_revcnt)) begin
                n_fail++; $display("FAIL revcnt_model cyc %0d: got %h/%0d, expected %h/%0d", cyc, dut_vec, rev_cnt, exp_vec(), m_revcnt);
            end
            if (rev_pulse) revs++;
            if (revs == 4) break;
        end
        n_chk++;
        if (rev_cnt !== 16'd3) begin n_fail++; $display("FAIL revcnt_three_revs: got %0d, expected 3", rev_cnt); end
        ena = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_random();
        int tt, n;
        for (int it = 0; it < 30; it++) begin
            tt = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
            teeth_total   = TW'(tt);
            teeth_missing = TW'($urandom_range(0, tt));
            period        = W'($urandom_range(0, 6));
            high_time     = W'($urandom_range(0, 8));
            load = 1'b1;
            ena  = ($urandom_range(0, 4) != 0);
            n = int'($urandom_range(5, 120));
            for (int cyc = 0; cyc < n; cyc++) begin
                @(negedge clk);
                load = 1'b0;
                n_chk++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++; $display("FAIL random_model it %0d cyc %0d: got %h, expected %h", it, cyc, dut_vec, exp_vec());
                end
`ifdef VR_WHEEL_GEN_REV_CNT_EN
                n_chk++;
                if (rev_cnt !== 16'(m_revcnt)) begin
                    n_fail++; $display("FAIL random_revcnt it %0d cyc %0d: got %0d, expected %0d", it, cyc, rev_cnt, m_revcnt);
                end
`endif
                if ($urandom_range(0, 40) == 0) ena = !ena;
            end
        end
    endtask

    initial begin
        test_reset();
        test_wheel_60_2();
        test_sanitise();
        test_invalid();
        test_retime();
        test_ena_drop();
        test_async_rst();
`ifdef VR_WHEEL_GEN_REV_CNT_EN
        test_rev_cnt();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vr_wheel_gen.md
# vr_wheel_gen

Synthetic crank trigger-wheel generator that drives the same single-bit VR line the angle generator's capture filter consumes. It models an N-tooth wheel with M consecutive missing teeth, producing a rectangular tooth waveform with programmable tooth period and high time. It sits in the test and bring-up path: its output feeds the hwag `vr_in` input on the board or in simulation. It also serves as a standalone stimulus source on boards without a real sensor.

## Interface

Parameters:
- `W`, 16: width of the period and high-time fields, in clock cycles.
- `TW`, 8: width of the tooth-count fields.

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ena` input 1: run enable; level-sensitive.
- `load` input 1: one-cycle strobe; captures the four config inputs below into shadow registers.
- `teeth_total` input TW: total tooth positions per revolution, real plus missing (e.g. 60).
- `teeth_missing` input TW: missing teeth per revolution (e.g. 2).
- `period` input W: clock cycles per tooth position.
- `high_time` input W: cycles `vr_out` is high within a real tooth.
- `vr_out` output 1: generated wheel signal.
- `tooth_num` output TW: index of the current tooth position.
- `gap` output 1: high while in missing-tooth positions.
- `rev_pulse` output 1: one-cycle pulse at the start of tooth 0.
- `busy` output 1: generator running.
- `cfg_err` output 1: active config is invalid.

## Operation

- Config registers:
  - Shadow registers take the inputs on `load`.
  - The active registers copy the shadow registers when idle, and at every revolution boundary, i.e. the cycle tooth 0 starts.
  - Retiming is therefore glitch-free; a partial revolution never mixes configs.
- Sanitising is applied on copy to active:
  - period < 2 becomes 2.
  - high_time = 0 becomes 1.
  - high_time >= period becomes period−1.
- Validity: the config is invalid if teeth_total = 0 or teeth_missing >= teeth_total.
  - When invalid, `cfg_err`=1 and the FSM holds in IDLE regardless of `ena`.
- FSM states: IDLE, HIGH, LOW, GAP.
  - IDLE → HIGH when `ena`=1 and the config is valid. Tooth 0 starts, `rev_pulse` fires and the phase counter clears.
  - HIGH → LOW when the phase counter reaches high_time−1.
  - LOW → HIGH (next tooth) when the phase counter reaches period−1, if more real teeth remain.
  - LOW → GAP after the last real tooth (index teeth_total−teeth_missing−1), when teeth_missing > 0.
  - LOW → HIGH with tooth 0 and `rev_pulse` after the last real tooth, when teeth_missing = 0.
  - GAP lasts teeth_missing×period cycles, with `tooth_num` advancing every period. It then wraps to HIGH, tooth 0, `rev_pulse`.
  - Any state → IDLE when `ena`=0. The stop is immediate and clears all counters.
- Outputs by state:
  - `vr_out` = 1 only in HIGH.
  - `gap` = 1 only in GAP.
  - `busy` = 1 in any state other than IDLE.
- Counters: the phase counter is W bits and the tooth counter is TW bits. Both wrap only by FSM control, never by overflow.

## Timing

- Reset values: `vr_out`=0, `tooth_num`=0, `gap`=0, `rev_pulse`=0, `busy`=0, `cfg_err`=1 (shadow and active config reset to 0, which is invalid).
- All outputs are registered.
- Startup: `ena` sampled high at edge k gives `vr_out`=1, `busy`=1 and `rev_pulse`=1 after edge k+1 (latency 1).
- `ena` low sampled at edge k gives all outputs at reset values (except `cfg_err`) after edge k+1.
- `load` while idle: config takes effect after 1 cycle. `cfg_err` updates on the same edge as the active copy.
- `load` while running: config takes effect at the next tooth-0 start.
- `load` and the revolution boundary in the same cycle: the boundary copies the old shadow value. The new value applies one revolution later.
- Revolution length = teeth_total×period cycles exactly.

## Configuration

- `VR_WHEEL_GEN_REV_CNT_EN`: when defined, adds output `rev_cnt` (16 bits).
  - `rev_cnt` resets to 0 on `rst` only; it does not clear on `ena`=0.
  - It increments on every `rev_pulse` except the first after leaving IDLE, and wraps from 0xFFFF to 0.
- Without the macro, the port and counter are absent and behaviour is otherwise identical.

## Test plan

- 60-2 wheel, period 10, high 5, load then `ena`=1:
  - 58 pulses, each 5 high / 5 low.
  - Then `gap`=1 for 20 cycles (25-cycle low stretch in total).
  - `rev_pulse` every 600 cycles; `tooth_num` runs 0..59.
- Sanitising: high_time=12, period=10 → 9 high / 1 low. period=1 → treated as 2.
- Invalid config: teeth_missing=60, teeth_total=60 → `cfg_err`=1, `busy` stays 0 with `ena`=1. Loading 60-2 clears it and starts within 2 cycles.
- Retime mid-revolution: load period 20 at tooth 30 → remaining teeth stay at period 10. The next revolution is 1200 cycles.
- `ena` dropped during HIGH of tooth 17 → next cycle all outputs are 0. Re-enable restarts at tooth 0 with `rev_pulse`.
- Async `rst` mid-GAP → outputs are reset immediately, without waiting for a clock edge. With `VR_WHEEL_GEN_REV_CNT_EN`: after 3 full revolutions `rev_cnt`=3, and after `rst` it is 0.
